// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_pkg
//  Description : Shared definitions for the serial parity link. Holds the
//                frame FSM state encoding, the parity polarity constants and
//                a helper that computes the parity bit for a frame. Both the
//                transmitter and the receiver side import this package.
//  Contents    : state_t      - frame FSM state encoding (2 bits)
//                PAR_EVEN     - polarity constant for even parity
//                PAR_ODD      - polarity constant for odd parity
//                MAX_WIDTH    - widest data word the link supports
//                frame_parity - parity bit for a word under a polarity
//  Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

    // Frame state machine encoding, shared with the receiver.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Parity polarity selectors.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Widest data word a frame may carry.
    localparam int MAX_WIDTH = 32;

    // Parity bit that makes the total count of ones in the frame (data plus
    // parity) even (polarity = PAR_EVEN) or odd (polarity = PAR_ODD).
    // Narrower words are zero-extended by the caller; zero bits do not
    // change the reduction, so one 32-bit helper serves every width.
    function automatic logic frame_parity(
        input logic [MAX_WIDTH-1:0] data,
        input logic                 polarity
    );
        return (^data) ^ polarity;
    endfunction

endpackage : parity_pkg
`default_nettype wire

// File: rtl/parity_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : parity_frame_tx
//  Description : Serial parity-frame transmitter. Accepts a WIDTH-bit word
//                over a valid/ready handshake and sends it LSB-first, one bit
//                per bit strobe, followed by a single parity bit. Frames may
//                be sent back-to-back with no idle gap.
//  Parameters  : WIDTH       - data bits per frame (2..32)
//                ODD_PARITY  - 0: even parity, 1: odd parity
//  Ports       : clk         - system clock, rising edge
//                rst         - asynchronous active-high reset
//                din         - word to transmit, sampled on the accept edge
//                din_valid   - din holds a word to send
//                din_ready   - block can accept a word this cycle
//                bit_en      - bit-rate strobe; serial output advances on it
//                x_out       - serial bit
//                x_valid     - x_out carries a frame bit
//                frame_start - data bit 0 is on x_out
//                frame_end   - parity bit is on x_out
//                busy        - a frame is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             bit_en,
    output logic             x_out,
    output logic             x_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Index counter width; it only ever needs to reach WIDTH-1.
    localparam int                 c_IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WIDTH - 1);
    localparam logic               c_POLARITY = (ODD_PARITY != 0) ? PAR_ODD : PAR_EVEN;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;    // remaining data bits, next bit in [0]
    logic [c_IDX_W-1:0] r_idx;      // index of the data bit on the line
    logic               r_par;      // parity bit of the frame in flight

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    state_t w_state_nxt;
    logic   w_accept;               // word taken on the coming edge
    logic   w_shift;                // data bit advances on the coming edge
    logic   w_par_load;             // parity of the word being accepted

    assign w_accept   = din_valid && din_ready;
    assign w_shift    = (r_state == ST_DATA) && bit_en;
    assign w_par_load = frame_parity(MAX_WIDTH'(din), c_POLARITY);

    // ------------------------------------------------------------------------
    // Next-state and output decode
    //
    // Every serial output is decoded from registered state only, so din,
    // din_valid and bit_en never reach x_out/x_valid/frame_* combinationally.
    // din_ready is the single exception: in ST_PARITY it follows bit_en so
    // that the next word is taken exactly on the edge that retires the
    // parity bit, giving back-to-back frames with no idle cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        din_ready   = 1'b0;
        x_out       = 1'b0;
        x_valid     = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        busy        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A load never waits for a strobe.
                din_ready = 1'b1;
                if (din_valid) begin
                    w_state_nxt = ST_DATA;
                end
            end

            ST_DATA: begin
                x_out       = r_shreg[0];
                x_valid     = 1'b1;
                frame_start = (r_idx == '0);
                busy        = 1'b1;
                if (bit_en && (r_idx == c_IDX_LAST)) begin
                    w_state_nxt = ST_PARITY;
                end
            end

            ST_PARITY: begin
                x_out     = r_par;
                x_valid   = 1'b1;
                frame_end = 1'b1;
                busy      = 1'b1;
                din_ready = bit_en;
                if (bit_en) begin
                    w_state_nxt = din_valid ? ST_DATA : ST_IDLE;
                end
            end

            default: begin
                // Unreachable encoding: present idle outputs, refuse any
                // word, and fall back to ST_IDLE on the next edge.
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    //
    // An accept always wins over a shift: in ST_PARITY the shift path is
    // idle anyway, and in ST_IDLE there is nothing to shift. The index keeps
    // counting past WIDTH-1 on the transition into ST_PARITY; that value is
    // never read because the shift register is only observed in ST_DATA.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_idx   <= '0;
            r_par   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_shreg <= din;
                r_idx   <= '0;
                r_par   <= w_par_load;
            end else if (w_shift) begin
                r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
                r_idx   <= r_idx + c_IDX_W'(1);
            end
        end
    end

endmodule : parity_frame_tx
`default_nettype wire

// File: tb/tb_parity_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_frame_tx
//  Description : Self-checking bench for parity_frame_tx. An even-parity and
//                an odd-parity instance share the same stimulus. Each
//                accepted word pushes its expected frame (data bits LSB-first
//                then parity) onto a per-instance queue; a negedge monitor
//                pops and compares each bit as the strobe retires it, and a
//                serial even-parity checker model watches the even instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_tx;

    localparam int c_W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [c_W-1:0] din = '0;
    logic           din_valid = 1'b0;
    logic           bit_en = 1'b1;

    logic din_ready_e, x_out_e, x_valid_e, frame_start_e, frame_end_e, busy_e;
    logic din_ready_o, x_out_o, x_valid_o, frame_start_o, frame_end_o, busy_o;

    parity_frame_tx #(.WIDTH(c_W), .ODD_PARITY(0)) u_dut_even (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_e), .bit_en(bit_en), .x_out(x_out_e),
        .x_valid(x_valid_e), .frame_start(frame_start_e),
        .frame_end(frame_end_e), .busy(busy_e)
    );

    parity_frame_tx #(.WIDTH(c_W), .ODD_PARITY(1)) u_dut_odd (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_o), .bit_en(bit_en), .x_out(x_out_o),
        .x_valid(x_valid_o), .frame_start(frame_start_o),
        .frame_end(frame_end_o), .busy(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic fs;
        logic fe;
    } exp_t;

    exp_t q_e[$];
    exp_t q_o[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic strobe_mode = 1'b0;
    logic chk_par = 1'b0;
    logic last_par_e = 1'b0;
    logic last_par_o = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit strobe: constant 1, or one cycle in three in strobed mode.
    initial begin : p_strobe
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (strobe_mode) begin
                cnt    = (cnt + 1) % 3;
                bit_en = (cnt == 0);
            end else begin
                cnt    = 0;
                bit_en = 1'b1;
            end
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            // ---------------- even instance ----------------
            if (x_valid_e) begin
                check("sb_nonempty_e", (q_e.size() > 0), 1'b1);
                if (q_e.size() > 0) begin
                    check("x_out_e", x_out_e, q_e[0].b);
                    check("frame_start_e", frame_start_e, q_e[0].fs);
                    check("frame_end_e", frame_end_e, q_e[0].fe);
                end
                check("busy_e", busy_e, 1'b1);
                check("din_ready_frame_e", din_ready_e, frame_end_e ? bit_en : 1'b0);
                if (frame_end_e) last_par_e = x_out_e;
                if (bit_en) begin
                    // Serial even-parity checker fed by gated x_out.
                    if (frame_start_e) begin
                        chk_par = x_out_e;
                    end else if (frame_end_e) begin
                        check("loopback_parity", chk_par ^ x_out_e, 1'b0);
                    end else begin
                        chk_par = chk_par ^ x_out_e;
                    end
                    if (q_e.size() > 0) void'(q_e.pop_front());
                end
            end else begin
                check("idle_x_out_e", x_out_e, 1'b0);
                check("idle_flags_e", {frame_start_e, frame_end_e, busy_e}, 3'b000);
                check("idle_ready_e", din_ready_e, 1'b1);
            end
            // ---------------- odd instance ----------------
            if (x_valid_o) begin
                check("sb_nonempty_o", (q_o.size() > 0), 1'b1);
                if (q_o.size() > 0) begin
                    check("x_out_o", x_out_o, q_o[0].b);
                    check("frame_flags_o", {frame_start_o, frame_end_o}, {q_o[0].fs, q_o[0].fe});
                end
                if (frame_end_o) last_par_o = x_out_o;
                if (bit_en && (q_o.size() > 0)) void'(q_o.pop_front());
            end else begin
                check("idle_o", {x_out_o, busy_o, din_ready_o}, 3'b001);
            end
            // ---------------- push on accept ----------------
            if (din_valid && din_ready_e) begin
                for (int i = 0; i < c_W; i++) begin
                    q_e.push_back('{b: din[i], fs: (i == 0), fe: 1'b0});
                    q_o.push_back('{b: din[i], fs: (i == 0), fe: 1'b0});
                end
                q_e.push_back('{b: (^din), fs: 1'b0, fe: 1'b1});
                q_o.push_back('{b: ~(^din), fs: 1'b0, fe: 1'b1});
            end
        end
    end

    // Offer a word and hold it until an edge where it is accepted.
    task automatic send(input logic [c_W-1:0] w);
        logic found;
        found     = 1'b0;
        din       = w;
        din_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (din_ready_e && bit_en) begin
                found = 1'b1;
                break;
            end
        end
        check("accept_timeout", found, 1'b1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    // Called right after the accept edge: bit 0 must be on the line in the
    // next cycle, and the frame must last exactly exp_len cycles.
    task automatic measure(input string tag, input int exp_len);
        int len;
        len = 0;
        @(negedge clk);
        check({tag, "_first_bit"}, {x_valid_e, frame_start_e}, 2'b11);
        while (x_valid_e && (len < 500)) begin
            len++;
            @(negedge clk);
        end
        check({tag, "_len"}, len, exp_len);
        check({tag, "_ready_after"}, {din_ready_e, busy_e}, 2'b10);
    endtask

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        int len;

        // ---------------- asynchronous reset ----------------
        #2;
        rst = 1'b1;
        #1;
        check("rst_outputs_e", {x_out_e, x_valid_e, frame_start_e, frame_end_e, busy_e}, 5'b0);
        check("rst_ready_e", din_ready_e, 1'b1);
        check("rst_outputs_o", {x_out_o, x_valid_o, busy_o, din_ready_o}, 4'b0001);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- basic frame ----------------
        send(8'hA5);
        measure("basic", c_W + 1);
        check("basic_par_e", last_par_e, 1'b0);

        // ---------------- parity polarity ----------------
        send(8'h07);
        measure("pol07", c_W + 1);
        check("pol07_par_e", last_par_e, 1'b1);
        check("pol07_par_o", last_par_o, 1'b0);
        send(8'h00);
        measure("pol00", c_W + 1);
        check("pol00_par_o", last_par_o, 1'b1);
        check("pol00_par_e", last_par_e, 1'b0);

        // ---------------- back-to-back ----------------
        send(8'hFF);
        din       = 8'h01;
        din_valid = 1'b1;
        len       = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!x_valid_e) break;
            len++;
            check("b2b_busy", busy_e, 1'b1);
            if (din_valid && din_ready_e) begin
                @(posedge clk);
                #1;
                din_valid = 1'b0;
            end
        end
        check("b2b_len", len, 2 * (c_W + 1));
        check("b2b_last_par_e", last_par_e, 1'b1);

        // ---------------- strobed rate ----------------
        strobe_mode = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(8'h3C);
        measure("strobe", 3 * (c_W + 1));
        strobe_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // ---------------- reset mid-frame ----------------
        send(8'hA5);
        repeat (5) @(negedge clk);
        check("midrst_pre_busy", busy_e, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_outputs", {x_valid_e, busy_e, x_out_e, frame_end_e}, 4'b0);
        check("midrst_ready", din_ready_e, 1'b1);
        check("midrst_outputs_o", {x_valid_o, busy_o, x_out_o}, 3'b0);
        q_e.delete();
        q_o.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(8'h81);
        measure("after_rst", c_W + 1);
        check("after_rst_par_e", last_par_e, 1'b0);

        // ---------------- loopback, random words ----------------
        for (int k = 0; k < 100; k++) begin
            send(8'($urandom));
            measure("loop", c_W + 1);
        end

        check("sb_drain_e", q_e.size(), 0);
        check("sb_drain_o", q_o.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_parity_frame_tx
`default_nettype wire
